pipeline_trace_buffer: RTL and testbench

In-hardware trace capture for the four-stage pipeline CPU. It records write-back events into a parametrised circular buffer, tagging each with the pipeline stall and flush activity seen since the previous entry. Capture stops on a selectable trigger, after a programmable number of post-trigger entries. It sits beside the CPU, taps the write-back and hazard signals, and exposes a registered read port so firmware or a bench can dump the history after a run.

---
 rtl/pipeline_trace_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_buffer.sv
// Write-back trace capture for the pipeline CPU: circular history of retiring
// register writes tagged with stall/flush activity, frozen a set number of entries after a trigger.
module pipeline_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [4:0]        trig_rd,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [AW:0]       post_count,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [4:0]        rd_rd,
    output logic [DATA_W-1:0] rd_data,
    output logic [PC_W-1:0]   rd_pc,
    output logic [1:0]        rd_flags,
    output logic [1:0]        state,
    output logic [AW:0]       count,
    output logic              triggered,
    output logic              done,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int ENTRY_W            = 5 + DATA_W + PC_W + 2;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [AW:0]          post_left_q, post_left_d;
    logic                 stall_seen_q, stall_seen_d;
    logic                 flush_seen_q, flush_seen_d;
    logic [15:0]          stall_cycles_q, stall_cycles_d;
    logic                 triggered_q, triggered_d;
    logic                 done_q;
    logic [1:0]           mode_q, mode_d;
    logic [4:0]           trig_rd_q, trig_rd_d;
    logic [PC_W-1:0]      trig_pc_q, trig_pc_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];

    logic                 active_s;
    logic                 cap_s;
    logic                 fire_s;
    logic                 wr_en_s;
    logic [ENTRY_W-1:0]   wr_entry_s;
    logic [AW:0]          post_clamp_s;
    logic [AW-1:0]        rd_idx_s;
    logic                 rd_oob_s;
    logic [ENTRY_W-1:0]   rd_entry_s;

    logic                 rd_valid_q;
    logic                 rd_err_q;
    logic [4:0]           rd_rd_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic [PC_W-1:0]      rd_pc_q;
    logic [1:0]           rd_flags_q;

    // Capture qualification, trigger match and read addressing relative to the oldest entry
    always_comb begin
        active_s     = (state_q == S_ARMED) || (state_q == S_POST);
        cap_s        = active_s && wb_valid && (wb_rd != 5'd0);
        post_clamp_s = (post_count > DEPTH_C) ? DEPTH_C : post_count;
        wr_entry_s   = {wb_rd, wb_data, wb_pc, stall_seen_q | stall_in, flush_seen_q | flush_in};
        rd_idx_s     = wr_ptr_q - count_q[AW-1:0] + rd_addr;
        rd_oob_s     = ({1'b0, rd_addr} >= count_q);
        rd_entry_s   = mem_q[rd_idx_s];
        case (mode_q)
            2'd1:    fire_s = cap_s && (wb_rd == trig_rd_q);
            2'd2:    fire_s = cap_s && (wb_pc == trig_pc_q);
            2'd3:    fire_s = flush_in;
            default: fire_s = 1'b0;
        endcase
    end

    // Next-state logic: arm overrides everything, otherwise capture/trigger sequencing
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        post_left_d    = post_left_q;
        stall_seen_d   = stall_seen_q;
        flush_seen_d   = flush_seen_q;
        stall_cycles_d = stall_cycles_q;
        triggered_d    = triggered_q;
        mode_d         = mode_q;
        trig_rd_d      = trig_rd_q;
        trig_pc_d      = trig_pc_q;
        wr_en_s        = 1'b0;
        if (arm) begin
            wr_ptr_d       = PTR_ZERO;
            count_d        = CNT_ZERO;
            stall_seen_d   = 1'b0;
            flush_seen_d   = 1'b0;
            stall_cycles_d = 16'd0;
            triggered_d    = 1'b0;
            mode_d         = trig_mode;
            trig_rd_d      = trig_rd;
            trig_pc_d      = trig_pc;
            post_left_d    = post_clamp_s;
            if (trig_mode == 2'd0) begin
                triggered_d = 1'b1;
                state_d     = (post_clamp_s == CNT_ZERO) ? S_DONE : S_POST;
            end else begin
                state_d     = S_ARMED;
            end
        end else if (active_s) begin
            if (stall_in && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_d = stall_cycles_q + 16'd1;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            // Flags restart from this cycle's activity once they have been stored
            if (cap_s) begin
                wr_en_s      = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                count_d      = (count_q == DEPTH_C) ? count_q : count_q + CNT_ONE;
                stall_seen_d = stall_in;
                flush_seen_d = flush_in;
            end else begin
                stall_seen_d = stall_seen_q | stall_in;
                flush_seen_d = flush_seen_q | flush_in;
            end
            case (state_q)
                S_ARMED: begin
                    if (fire_s) begin
                        triggered_d = 1'b1;
                        if ((mode_q == 2'd3) && cap_s && (post_left_q != CNT_ZERO)) begin
                            post_left_d = post_left_q - CNT_ONE;
                        end else begin
                            post_left_d = post_left_q;
                        end
                        state_d = (post_left_d == CNT_ZERO) ? S_DONE : S_POST;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_POST: begin
                    if (cap_s) begin
                        post_left_d = post_left_q - CNT_ONE;
                        state_d     = (post_left_q == CNT_ONE) ? S_DONE : S_POST;
                    end else begin
                        state_d     = S_POST;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= PTR_ZERO;
            count_q        <= CNT_ZERO;
            post_left_q    <= CNT_ZERO;
            stall_seen_q   <= 1'b0;
            flush_seen_q   <= 1'b0;
            stall_cycles_q <= 16'd0;
            triggered_q    <= 1'b0;
            done_q         <= 1'b0;
            mode_q         <= 2'd0;
            trig_rd_q      <= 5'd0;
            trig_pc_q      <= {PC_W{1'b0}};
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            post_left_q    <= post_left_d;
            stall_seen_q   <= stall_seen_d;
            flush_seen_q   <= flush_seen_d;
            stall_cycles_q <= stall_cycles_d;
            triggered_q    <= triggered_d;
            done_q         <= (state_d == S_DONE);
            mode_q         <= mode_d;
            trig_rd_q      <= trig_rd_d;
            trig_pc_q      <= trig_pc_d;
        end
    end

    // Trace RAM; left uninitialised since count gates every read
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    // Registered read port; sees the RAM as it was before a same-edge capture
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_rd_q    <= 5'd0;
            rd_data_q  <= {DATA_W{1'b0}};
            rd_pc_q    <= {PC_W{1'b0}};
            rd_flags_q <= 2'd0;
        end else if (rd_en) begin
            rd_valid_q <= 1'b1;
            rd_err_q   <= rd_oob_s;
            if (rd_oob_s) begin
                rd_rd_q    <= 5'd0;
                rd_data_q  <= {DATA_W{1'b0}};
                rd_pc_q    <= {PC_W{1'b0}};
                rd_flags_q <= 2'd0;
            end else begin
                rd_rd_q    <= rd_entry_s[ENTRY_W-1 -: 5];
                rd_data_q  <= rd_entry_s[2+PC_W +: DATA_W];
                rd_pc_q    <= rd_entry_s[2 +: PC_W];
                rd_flags_q <= rd_entry_s[1:0];
            end
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_err       = rd_err_q;
    assign rd_rd        = rd_rd_q;
    assign rd_data      = rd_data_q;
    assign rd_pc        = rd_pc_q;
    assign rd_flags     = rd_flags_q;
    assign state        = state_q;
    assign count        = count_q;
    assign triggered    = triggered_q;
    assign done         = done_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the trace history.
module tb_pipeline_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset, wb_valid, stall_in, flush_in, arm, rd_en;
    logic [4:0]  wb_rd, trig_rd;
    logic [31:0] wb_data, wb_pc, trig_pc;
    logic [1:0]  trig_mode;
    logic [AW:0] post_count;
    logic [AW-1:0] rd_addr;
    logic        rd_valid, rd_err, triggered, done;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data, rd_pc;
    logic [1:0]  rd_flags, state;
    logic [AW:0] count;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_trace_buffer #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .stall_in(stall_in), .flush_in(flush_in), .arm(arm),
        .trig_mode(trig_mode), .trig_rd(trig_rd), .trig_pc(trig_pc), .post_count(post_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_err(rd_err),
        .rd_rd(rd_rd), .rd_data(rd_data), .rd_pc(rd_pc), .rd_flags(rd_flags),
        .state(state), .count(count), .triggered(triggered), .done(done),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [1:0]  flags;
    } ent_t;

    ent_t        mq[$];
    int          m_state = 0, m_stall = 0, m_mode = 0, m_post = 0;
    bit          m_trig = 0, m_ss = 0, m_fs = 0;
    logic [4:0]  m_trd;
    logic [31:0] m_tpc;
    bit          e_rv, e_err;
    ent_t        e_ent;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: advances one clock edge using the inputs currently applied
    task automatic model_step();
        bit cap, fire;
        e_rv = !reset && rd_en;
        if (rd_en) begin
            e_err = (int'(rd_addr) >= mq.size());
            if (e_err) e_ent = '{5'd0, 32'd0, 32'd0, 2'd0};
            else       e_ent = mq[rd_addr];
        end
        if (reset) begin
            mq.delete(); m_state = 0; m_trig = 0; m_stall = 0; m_ss = 0; m_fs = 0;
        end else if (arm) begin
            mq.delete(); m_ss = 0; m_fs = 0; m_stall = 0; m_trig = 0;
            m_mode = trig_mode; m_trd = trig_rd; m_tpc = trig_pc;
            m_post = (int'(post_count) > DEPTH) ? DEPTH : int'(post_count);
            if (trig_mode == 2'd0) begin
                m_trig  = 1;
                m_state = (m_post == 0) ? 3 : 2;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 1 || m_state == 2) begin
            cap = wb_valid && (wb_rd != 5'd0);
            if (stall_in && m_stall < 65535) m_stall++;
            if (cap) begin
                mq.push_back('{wb_rd, wb_data, wb_pc, {m_ss | stall_in, m_fs | flush_in}});
                if (mq.size() > DEPTH) mq.delete(0);
                m_ss = stall_in; m_fs = flush_in;
            end else begin
                m_ss = m_ss | stall_in; m_fs = m_fs | flush_in;
            end
            if (m_state == 1) begin
                fire = (m_mode == 1 && cap && wb_rd == m_trd) ||
                       (m_mode == 2 && cap && wb_pc == m_tpc) ||
                       (m_mode == 3 && flush_in);
                if (fire) begin
                    m_trig = 1;
                    if (m_mode == 3 && cap && m_post > 0) m_post--;
                    m_state = (m_post == 0) ? 3 : 2;
                end
            end else if (cap) begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", state, m_state);
        chk("count", count, mq.size());
        chk("triggered", triggered, m_trig);
        chk("done", done, m_state == 3);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("rd_valid", rd_valid, e_rv);
        if (e_rv) begin
            chk("rd_err", rd_err, e_err);
            chk("rd_rd", rd_rd, e_ent.rd);
            chk("rd_data", rd_data, e_ent.data);
            chk("rd_pc", rd_pc, e_ent.pc);
            chk("rd_flags", rd_flags, e_ent.flags);
        end
    endtask

    task automatic cyc();
        tick();
        wb_valid = 0; stall_in = 0; flush_in = 0; arm = 0; rd_en = 0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [4:0] trd, input logic [31:0] tpc,
                          input logic [AW:0] pcnt);
        arm = 1; trig_mode = m; trig_rd = trd; trig_pc = tpc; post_count = pcnt;
        cyc();
    endtask

    task automatic do_wb(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
        wb_valid = 1; wb_rd = r; wb_data = d; wb_pc = p;
        cyc();
    endtask

    task automatic do_rd(input logic [AW-1:0] a);
        rd_en = 1; rd_addr = a;
        cyc();
    endtask

    initial begin
        reset = 1; wb_valid = 0; wb_rd = 0; wb_data = 0; wb_pc = 0; stall_in = 0;
        flush_in = 0; arm = 0; trig_mode = 0; trig_rd = 0; trig_pc = 0; post_count = 0;
        rd_en = 0; rd_addr = 0;

        // Reset
        cyc(); cyc();
        reset = 0;
        chk("reset_state", state, 2'd0);
        chk("reset_count", count, 5'd0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        do_rd(4'd0);
        chk("reset_rd_err", rd_err, 1'b1);
        chk("reset_rd_data", rd_data, 32'd0);

        // Basic capture, immediate trigger
        do_arm(2'd0, 5'd0, 32'd0, 5'd3);
        chk("basic_post_state", state, 2'd2);
        do_wb(5'd1, 32'd5, 32'h100);
        do_wb(5'd2, 32'd2, 32'h104);
        do_wb(5'd3, 32'd7, 32'h108);
        chk("basic_done", done, 1'b1);
        chk("basic_count", count, 5'd3);
        do_rd(4'd0); chk("basic_rd0_rd", rd_rd, 5'd1); chk("basic_rd0_data", rd_data, 32'd5);
        do_rd(4'd1); chk("basic_rd1_rd", rd_rd, 5'd2); chk("basic_rd1_data", rd_data, 32'd2);
        do_rd(4'd2); chk("basic_rd2_rd", rd_rd, 5'd3); chk("basic_rd2_data", rd_data, 32'd7);
        do_wb(5'd4, 32'd9, 32'h10c);
        chk("basic_frozen_count", count, 5'd3);

        // Wrap with rd-match trigger
        do_arm(2'd1, 5'd13, 32'd0, 5'd2);
        for (int i = 0; i < 20; i++) do_wb(5'((i % 12) + 1), 32'(1000 + i), 32'(4 * i));
        do_wb(5'd13, 32'd2000, 32'h200);
        chk("wrap_trig_state", state, 2'd2);
        do_wb(5'd14, 32'd2001, 32'h204);
        do_wb(5'd15, 32'd2002, 32'h208);
        chk("wrap_done", done, 1'b1);
        chk("wrap_count", count, 5'd16);
        do_rd(4'd13); chk("wrap_a13", rd_rd, 5'd13);
        do_rd(4'd15); chk("wrap_a15", rd_rd, 5'd15);
        do_rd(4'd0);  chk("wrap_oldest_rd", rd_rd, 5'd8); chk("wrap_oldest_data", rd_data, 32'd1007);

        // x0 filtering and sticky flags
        do_arm(2'd1, 5'd31, 32'd0, 5'd0);
        do_wb(5'd0, 32'hdead, 32'h300);
        chk("x0_ignored", count, 5'd0);
        stall_in = 1; cyc();
        do_wb(5'd5, 32'h55, 32'h304);
        do_wb(5'd6, 32'h66, 32'h308);
        flush_in = 1; do_wb(5'd7, 32'h77, 32'h30c);
        do_rd(4'd0); chk("flags_stall", rd_flags, 2'b10);
        do_rd(4'd1); chk("flags_clear", rd_flags, 2'b00);
        do_rd(4'd2); chk("flags_flush_same", rd_flags, 2'b01);

        // Flush trigger with a same-cycle capture
        do_arm(2'd3, 5'd0, 32'd0, 5'd1);
        cyc();
        flush_in = 1; do_wb(5'd4, 32'h44, 32'h400);
        chk("m3_done_state", state, 2'd3);
        chk("m3_count", count, 5'd1);
        do_rd(4'd0); chk("m3_last_rd", rd_rd, 5'd4);

        // arm priority, arm-cycle capture ignored, reset mid-POST
        wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h99; wb_pc = 32'h500;
        do_arm(2'd0, 5'd0, 32'd0, 5'd5);
        chk("arm_cap_ignored", count, 5'd0);
        do_wb(5'd1, 32'h1, 32'h504);
        do_wb(5'd2, 32'h2, 32'h508);
        do_arm(2'd2, 5'd0, 32'h40, 5'd4);
        chk("rearm_state", state, 2'd1);
        chk("rearm_count", count, 5'd0);
        do_wb(5'd3, 32'h3, 32'h40);
        chk("pc_trig", triggered, 1'b1);
        reset = 1; cyc(); reset = 0;
        chk("midpost_reset_state", state, 2'd0);
        chk("midpost_reset_count", count, 5'd0);

        // Random traffic against the model
        for (int ep = 0; ep < 8; ep++) begin
            do_arm(2'($urandom_range(0, 3)), 5'($urandom_range(1, 7)),
                   32'(4 * $urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            for (int c = 0; c < 80; c++) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_rd    = 5'($urandom_range(0, 7));
                wb_data  = $urandom;
                wb_pc    = 32'(4 * $urandom_range(0, 7));
                stall_in = ($urandom_range(0, 3) == 0);
                flush_in = ($urandom_range(0, 7) == 0);
                rd_en    = $urandom_range(0, 1);
                rd_addr  = 4'($urandom_range(0, 15));
                arm      = ($urandom_range(0, 49) == 0);
                trig_mode = 2'($urandom_range(0, 3));
                post_count = 5'($urandom_range(0, 31));
                reset    = ($urandom_range(0, 199) == 0);
                cyc();
                reset = 0;
            end
        end

        // stall_cycles saturation
        do_arm(2'd1, 5'd31, 32'd0, 5'd0);
        stall_in = 1;
        for (int i = 0; i < 70000; i++) tick();
        stall_in = 0;
        chk("stall_sat", stall_cycles, 16'hFFFF);
        do_arm(2'd1, 5'd31, 32'd0, 5'd0);
        chk("stall_clear_on_arm", stall_cycles, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
